// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: multi-cycle EX-stage ALU. Base integer and branch-compare
// operations finish in one pass; RV32M multiply/divide iterate for WIDTH cycles.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake (accepted when both high)
//   ctrl                   operation code
//   rdata1, rdata2, imm    operand 1, operand 2 (register), operand 2 (immediate)
//   alu_src                operand 2 select: 0 = rdata2, 1 = imm
//   out_valid / out_ready  result handshake
//   result, cond           result word and branch-taken flag
//   busy                   multiply/divide iterating
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | multiply/divide iterating, one step per clock
// DONE  | result/cond held, waiting for out_ready
module alu_seq_muldiv #(
  parameter int WIDTH     = 32,
  parameter int CTRL_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_BITS-1:0] ctrl,
  input  logic [WIDTH-1:0]     rdata1,
  input  logic [WIDTH-1:0]     rdata2,
  input  logic [WIDTH-1:0]     imm,
  input  logic                 alu_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 cond,
  output logic                 busy
);
  localparam int SHAMT_BITS = $clog2(WIDTH);
  localparam int CNT_BITS   = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [CNT_BITS-1:0]   cnt;
  logic [2*WIDTH-1:0]    acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]      opb;       // mul: multiplicand magnitude; div: divisor magnitude
  logic [WIDTH-1:0]      dividend;
  logic [2:0]            md_op;
  logic                  neg_res, neg_rem, div_zero;

  // Single-pass datapath
  logic [WIDTH-1:0]      op2, diff, alu_res;
  logic [SHAMT_BITS-1:0] shamt;
  logic                  alu_cond, lt_s, lt_u, is_muldiv;

  assign op2       = alu_src ? imm : rdata2;
  assign shamt     = op2[SHAMT_BITS-1:0];
  assign diff      = rdata1 - op2;
  assign lt_s      = $signed(rdata1) < $signed(op2);
  assign lt_u      = rdata1 < op2;
  assign is_muldiv = (int'(ctrl) >= 16) && (int'(ctrl) <= 23);

  always_comb begin
    alu_res  = '0;
    alu_cond = 1'b0;
    case (int'(ctrl))
      0:  alu_res = rdata1 + op2;
      1:  alu_res = diff;
      2:  alu_res = rdata1 & op2;
      3:  alu_res = rdata1 | op2;
      4:  alu_res = rdata1 ^ op2;
      5:  alu_res = rdata1 << shamt;
      6:  alu_res = rdata1 >> shamt;
      7:  alu_res = $unsigned($signed(rdata1) >>> shamt);
      8:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      9:  alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      10: begin alu_res = diff; alu_cond = (rdata1 == op2); end
      11: begin alu_res = diff; alu_cond = (rdata1 != op2); end
      12: begin alu_res = diff; alu_cond = lt_s;  end
      13: begin alu_res = diff; alu_cond = !lt_s; end
      14: begin alu_res = diff; alu_cond = lt_u;  end
      15: begin alu_res = diff; alu_cond = !lt_u; end
      default: ;
    endcase
  end

  // Operand signs/magnitudes for the iterative unit, formed at accept time
  logic [2:0]       md_sel;
  logic             signed1, signed2, neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;

  assign md_sel  = ctrl[2:0];
  assign signed1 = md_sel[2] ? !md_sel[0] : (md_sel[1:0] != 2'd3);
  assign signed2 = md_sel[2] ? !md_sel[0] : (md_sel[1:0] <= 2'd1);
  assign neg1    = signed1 & rdata1[WIDTH-1];
  assign neg2    = signed2 & op2[WIDTH-1];
  assign mag1    = neg1 ? -rdata1 : rdata1;
  assign mag2    = neg2 ? -op2 : op2;

  // One iteration step for each algorithm
  logic [WIDTH:0]     mul_sum, div_shift, div_sub;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_full;
  logic [WIDTH-1:0]   quo, rem, md_res;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_sub   = div_shift - {1'b0, opb};
  // Restore when the trial subtraction borrows; the quotient bit is the inverted borrow.
  assign div_next  = {(div_sub[WIDTH] ? div_shift[WIDTH-1:0] : div_sub[WIDTH-1:0]),
                      acc[WIDTH-2:0], ~div_sub[WIDTH]};
  assign mul_full  = neg_res ? -mul_next : mul_next;
  assign quo       = div_next[WIDTH-1:0];
  assign rem       = div_next[2*WIDTH-1:WIDTH];

  always_comb begin
    case (md_op)
      3'd0:       md_res = mul_full[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:       md_res = mul_full[2*WIDTH-1:WIDTH];
      3'd4, 3'd5: md_res = div_zero ? '1 : (neg_res ? -quo : quo);
      default:    md_res = div_zero ? dividend : (neg_rem ? -rem : rem);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      cond      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      dividend  <= '0;
      md_op     <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (is_muldiv) begin
            md_op    <= md_sel;
            neg_res  <= neg1 ^ neg2;
            neg_rem  <= neg1;
            div_zero <= (op2 == '0);
            dividend <= rdata1;
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend out.
            acc      <= {{WIDTH{1'b0}}, (md_sel[2] ? mag1 : mag2)};
            opb      <= md_sel[2] ? mag2 : mag1;
            cnt      <= CNT_BITS'(WIDTH);
            cond     <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
          end else begin
            result    <= alu_res;
            cond      <= alu_cond;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        BUSY: begin
          acc <= md_op[2] ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_BITS'(1)) begin
            result    <= md_res;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv (WIDTH=32): a reference model computes
// result/cond from plain arithmetic, a negedge process compares every cycle
// out_valid is high, and selected vectors also carry hand-computed literals.
module tb_alu_seq_muldiv;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, alu_src = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, cond, busy;
  logic [4:0]  ctrl = '0;
  logic [31:0] rdata1 = '0, rdata2 = '0, imm = '0, result;

  int          checks = 0, failures = 0;
  logic [31:0] exp_res = '0;
  logic        exp_cond = 1'b0;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.WIDTH(32), .CTRL_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .rdata1(rdata1), .rdata2(rdata2), .imm(imm), .alu_src(alu_src),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cond(cond),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Returns {cond, result}
  function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic        c;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    c  = 1'b0;
    p  = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: begin r = a - b; c = (a == b);  end
      5'd11: begin r = a - b; c = (a != b);  end
      5'd12: begin r = a - b; c = (sa < sb); end
      5'd13: begin r = a - b; c = (sa >= sb); end
      5'd14: begin r = a - b; c = (a < b);   end
      5'd15: begin r = a - b; c = (a >= b);  end
      5'd16, 5'd17: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = (op == 5'd16) ? p[31:0] : p[63:32]; end
      5'd18: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; end
      5'd19: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      5'd20: if (b == 0) r = '1;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
             else r = sa / sb;
      5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: if (b == 0) r = a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
             else r = sa % sb;
      5'd23: r = (b == 0) ? a : a % b;
      default: ;
    endcase
    return {c, r};
  endfunction

  // Result/cond must match the model (and stay stable) whenever out_valid is high.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("result", result, exp_res);
      chk("cond", 32'(cond), 32'(exp_cond));
      chk("busy_in_done", 32'(busy), 32'd0);
    end
  end

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] r2,
                        input logic [31:0] im, input logic src, input int hold,
                        input logic lit_on, input logic [31:0] lit_res, input logic lit_cond);
    logic [32:0] m;
    logic [31:0] b;
    int          lat, exp_lat;
    b       = src ? im : r2;
    m       = model(op, a, b);
    exp_lat = (op >= 5'd16 && op <= 5'd23) ? 33 : 1;
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 100) begin @(negedge clk); lat++; end
    chk("idle_before_issue", 32'(in_ready), 32'd1);
    exp_res  = m[31:0];
    exp_cond = m[32];
    ctrl = op; rdata1 = a; rdata2 = r2; imm = im; alu_src = src; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdata1 = ~a; rdata2 = ~r2; imm = ~im;   // operands must have been captured
    lat = 1;
    @(negedge clk);
    if (exp_lat > 1) begin
      chk("busy_iterating", 32'(busy), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
    end
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (lit_on) begin
      chk("lit_result", result, lit_res);
      chk("lit_cond", 32'(cond), 32'(lit_cond));
    end
    for (int i = 0; i < hold; i++) begin
      ctrl = 5'd0; rdata1 = 32'd10; rdata2 = 32'd20; alu_src = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk("no_accept_in_done", 32'(in_ready), 32'd0);
      chk("valid_held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cond", 32'(cond), 32'd0);
    rst_n = 1'b1;

    //     op     rdata1        rdata2        imm           src  hold lit  lit_res       lit_cond
    run_op(5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 0, 1'b1, 32'h80000000, 1'b0);
    run_op(5'd1,  32'h00000005, 32'h00000007, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFE, 1'b0);
    run_op(5'd2,  32'hF0F0F0F0, 32'h00000000, 32'h0FF00FF0, 1'b1, 0, 1'b1, 32'h00F000F0, 1'b0);
    run_op(5'd3,  32'h00001200, 32'h00000034, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b0);
    run_op(5'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b0);
    run_op(5'd5,  32'h00000001, 32'h00000025, 32'h0,        1'b0, 0, 1'b1, 32'h00000020, 1'b0);
    run_op(5'd6,  32'h80000000, 32'h0000001F, 32'h0,        1'b0, 0, 1'b1, 32'h00000001, 1'b0);
    run_op(5'd7,  32'h80000000, 32'h00000004, 32'h0,        1'b0, 0, 1'b1, 32'hF8000000, 1'b0);
    run_op(5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 0, 1'b1, 32'h00000001, 1'b0);
    run_op(5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 0, 1'b1, 32'h00000000, 1'b0);
    run_op(5'd14, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 0, 1'b1, 32'h00000002, 1'b1);
    run_op(5'd12, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 0, 1'b1, 32'h00000002, 1'b0);
    run_op(5'd10, 32'h00000005, 32'h00000005, 32'h0,        1'b0, 0, 1'b1, 32'h00000000, 1'b1);
    run_op(5'd11, 32'h00000005, 32'h00000005, 32'h0,        1'b0, 0, 1'b1, 32'h00000000, 1'b0);
    run_op(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b0);
    run_op(5'd15, 32'h00000003, 32'h00000004, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op(5'd17, 32'h80000000, 32'h80000000, 32'h0,        1'b0, 0, 1'b1, 32'h40000000, 1'b0);
    run_op(5'd16, 32'h80000000, 32'h80000000, 32'h0,        1'b0, 0, 1'b1, 32'h00000000, 1'b0);
    run_op(5'd18, 32'hFFFFFFFF, 32'h00000002, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFE, 1'b0);
    run_op(5'd16, 32'hFFFFFFFD, 32'h00000007, 32'h0,        1'b0, 5, 1'b1, 32'hFFFFFFEB, 1'b0);
    run_op(5'd17, 32'hFFFFFFFD, 32'h00000007, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 0, 1'b1, 32'h80000000, 1'b0);
    run_op(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 0, 1'b1, 32'h00000000, 1'b0);
    run_op(5'd21, 32'h00000007, 32'h00000000, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op(5'd23, 32'h00000007, 32'h00000000, 32'h0,        1'b0, 0, 1'b1, 32'h00000007, 1'b0);
    run_op(5'd20, 32'hFFFFFFF9, 32'h00000002, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFD, 1'b0);
    run_op(5'd22, 32'hFFFFFFF9, 32'h00000002, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op(5'd20, 32'hFFFFFFFB, 32'h00000000, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_op(5'd22, 32'hFFFFFFFB, 32'h00000000, 32'h0,        1'b0, 0, 1'b1, 32'hFFFFFFFB, 1'b0);
    run_op(5'd21, 32'h00000064, 32'hDEADBEEF, 32'h00000007, 1'b1, 0, 1'b1, 32'h0000000E, 1'b0);
    run_op(5'd27, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b0, 0, 1'b1, 32'h00000000, 1'b0);
    run_op(5'd0,  32'h00000011, 32'h00000022, 32'h0,        1'b0, 5, 1'b1, 32'h00000033, 1'b0);

    // Reset pulsed in the middle of a divide
    @(negedge clk);
    ctrl = 5'd20; rdata1 = 32'd100; rdata2 = 32'd7; alu_src = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(5'd0, 32'd2, 32'd3, 32'h0, 1'b0, 0, 1'b1, 32'd5, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
